// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl
//
// Load/store master for a word-organised synchronous data RAM. Takes one
// byte/half/word request at a time from the MEM stage. It runs sub-word
// stores as a read-modify-write and sign- or zero-extends load data.
// Misaligned, illegal-size or out-of-range requests return an error
// response and never touch the RAM.
//
// Optional feature macro: LSU_WORD_STORE_BYPASS_EN
//   When defined, a legal aligned word store skips the RAM read and goes
//   straight to the write cycle.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   req_valid/ready request handshake; ready only while idle
//   req_we          1 = store, 0 = load
//   req_addr        byte address
//   req_size        00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned    loads: 1 = zero-extend, 0 = sign-extend
//   req_wdata       right-aligned store data
//   resp_valid      one-cycle completion pulse
//   resp_rdata      extended load data (0 for stores and errors)
//   resp_err        error flag, qualified by resp_valid
//   ram_index       RAM word index
//   ram_entry       RAM write data
//   ram_wr_en       RAM write enable
//   ram_entry_out   RAM read data, valid the cycle after the index is sampled

module lsu_mem_ctrl #(
    parameter int unsigned RAM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ram_index,
    output logic [31:0] ram_entry,
    output logic        ram_wr_en,
    input  logic [31:0] ram_entry_out
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DATA,
        WRITE,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        accept;
    logic        req_err;
    logic        word_bypass;

    logic        lat_we;
    logic [1:0]  lat_off;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lat_wdata;

    logic [4:0]  lane_shift;
    logic [31:0] lane_word;
    logic [31:0] lane_mask;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign accept     = req_valid && req_ready;
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    // Decoded straight from state so an asynchronous reset drops the write
    // enable immediately and an in-flight write is abandoned.
    assign ram_wr_en  = (state == WRITE);

`ifdef LSU_WORD_STORE_BYPASS_EN
    // A full aligned word overwrites every lane, so the old word is not needed.
    assign word_bypass = req_we && (req_size == 2'b10);
`else
    assign word_bypass = 1'b0;
`endif

    // Request legality, evaluated on the live request fields at accept time.
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = (req_addr[1:0] != 2'b00);
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if ({2'b00, req_addr[31:2]} >= RAM_WORDS) begin
            req_err = 1'b1;
        end
    end

    // Lane handling for the word returned by the RAM. Little-endian: the
    // addressed lane is shifted down to bit 0 for loads, and the store data
    // is shifted up into that lane for merges.
    always_comb begin
        lane_shift = {lat_off, 3'b000};
        lane_word  = ram_entry_out >> lane_shift;
        lane_mask  = 32'hFFFF_FFFF;
        load_ext   = ram_entry_out;
        case (lat_size)
            2'b00: begin
                lane_mask = 32'h0000_00FF;
                load_ext  = {{24{~lat_unsigned & lane_word[7]}}, lane_word[7:0]};
            end
            2'b01: begin
                lane_mask = 32'h0000_FFFF;
                load_ext  = {{16{~lat_unsigned & lane_word[15]}}, lane_word[15:0]};
            end
            default: begin
                lane_mask = 32'hFFFF_FFFF;
                load_ext  = ram_entry_out;
            end
        endcase
        merged = (ram_entry_out & ~(lane_mask << lane_shift))
               | ((lat_wdata & lane_mask) << lane_shift);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Errors go straight to the response cycle; legal
    // requests read the RAM first unless the word-store bypass applies.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_next = RESP;
                    end else if (word_bypass) begin
                        state_next = WRITE;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE:   state_next = DATA;
            DATA:    state_next = lat_we ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers. Response fields only change on the transition into
    // RESP, so they hold their values until the next response. RAM index and
    // entry are only touched by legal requests and hold while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we       <= 1'b0;
            lat_off      <= 2'b00;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_wdata    <= 32'h0;
            resp_rdata   <= 32'h0;
            resp_err     <= 1'b0;
            ram_index    <= 32'h0;
            ram_entry    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_we       <= req_we;
                        lat_off      <= req_addr[1:0];
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_wdata    <= req_wdata;
                        if (req_err) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            ram_index <= {2'b00, req_addr[31:2]};
                            if (word_bypass) begin
                                ram_entry <= req_wdata;
                            end
                        end
                    end
                end
                DATA: begin
                    if (lat_we) begin
                        ram_entry <= merged;
                    end else begin
                        resp_rdata <= load_ext;
                        resp_err   <= 1'b0;
                    end
                end
                WRITE: begin
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
